// File: rtl/mc_pkg.sv
// Shared types and constants for the memory-controller command scheduler.
package mc_pkg;

  // Default width of the refresh interval timer.
  localparam int RF_CNT_W_DEF = 16;

  // APB register offsets that feed the scheduler configuration.
  localparam int APB_REG_CTRL      = 0;
  localparam int APB_REG_RF_PERIOD = 12;

  // Who currently owns the array port; IDLE means nobody.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RF   = 2'd3
  } state_e;

  // One-hot grant vector presented to the requesters.
  typedef struct packed {
    logic rf;
    logic rd;
    logic wr;
  } owner_t;

  // Decode the owning state into its one-hot grant vector.
  function automatic owner_t ownerOf(input state_e s);
    owner_t o;
    o = '0;
    case (s)
      ST_WR:   o.wr = 1'b1;
      ST_RD:   o.rd = 1'b1;
      ST_RF:   o.rf = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_rf_timer.sv
// Free-running refresh interval timer. Counts 0..period-1 while enabled and
// flags a one-cycle expire on the terminal count. The period is sampled at
// the start of every interval so a reprogrammed value only applies after the
// current interval wraps.
module mc_rf_timer
  import mc_pkg::*;
#(
  parameter int RF_CNT_W = RF_CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cfgEn_i,
  input  logic [RF_CNT_W-1:0] period_i,
  output logic                expire_o
);

  localparam logic [RF_CNT_W-1:0] ONE = RF_CNT_W'(1);

  logic [RF_CNT_W-1:0] cnt_q, cnt_d;
  logic [RF_CNT_W-1:0] per_q;
  logic [RF_CNT_W-1:0] perClamp;
  logic [RF_CNT_W-1:0] perEff;

  // Clamp a zero period to one, pick the live period at interval start, and
  // compute the terminal-count expiry and next counter value.
  always_comb begin
    perClamp = (period_i == '0) ? ONE : period_i;
    perEff   = (cnt_q == '0) ? perClamp : per_q;
    expire_o = cfgEn_i && (cnt_q == (perEff - ONE));
    cnt_d    = '0;
    if (cfgEn_i && !expire_o) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter and the period captured for the interval in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      per_q <= ONE;
    end else begin
      cnt_q <= cnt_d;
      per_q <= perEff;
    end
  end

endmodule

// File: rtl/mc_sched.sv
// Array-port command scheduler: pending refreshes win outright, otherwise
// write and read alternate round-robin. Exactly one owner at a time, held
// until that owner's done pulse.
module mc_sched
  import mc_pkg::*;
#(
  parameter int RF_CNT_W = RF_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic [RF_CNT_W-1:0] cfg_rf_period,
  input  logic                wr_req,
  input  logic                wr_done,
  input  logic                rd_req,
  input  logic                rd_done,
  input  logic                rf_done,
  output logic                wr_gnt,
  output logic                rd_gnt,
  output logic                rf_gnt,
  output logic                busy,
  output logic [1:0]          rf_pend_cnt,
  output logic                rf_overflow
);

  state_e     state_q, state_d;
  logic       lastWr_q, lastWr_d;
  logic [1:0] pendCnt_q, pendCnt_d;
  logic       overflow_q, overflow_d;
  logic       expire;
  logic       rfStart;
  owner_t     grant;

  mc_rf_timer #(
    .RF_CNT_W(RF_CNT_W)
  ) u_rf_timer (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .cfgEn_i  (cfg_en),
    .period_i (cfg_rf_period),
    .expire_o (expire)
  );

  // Ownership decision in IDLE and release on the owner's own done pulse.
  always_comb begin
    state_d  = state_q;
    lastWr_d = lastWr_q;
    rfStart  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en) begin
          if (pendCnt_q != 2'd0) begin
            state_d = ST_RF;
            rfStart = 1'b1;
          end else if (wr_req && (!rd_req || !lastWr_q)) begin
            state_d  = ST_WR;
            lastWr_d = 1'b1;
          end else if (rd_req) begin
            state_d  = ST_RD;
            lastWr_d = 1'b0;
          end
        end
      end
      ST_WR:   if (wr_done) state_d = ST_IDLE;
      ST_RD:   if (rd_done) state_d = ST_IDLE;
      ST_RF:   if (rf_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding refresh bookkeeping: expiries add, starting a refresh
  // subtracts, both together cancel; saturation at 3 latches the overflow.
  always_comb begin
    pendCnt_d  = pendCnt_q;
    overflow_d = overflow_q;
    if (!cfg_en) begin
      pendCnt_d = 2'd0;
    end else begin
      if (expire && (pendCnt_q == 2'd3)) begin
        overflow_d = 1'b1;
      end
      if (expire && !rfStart && (pendCnt_q != 2'd3)) begin
        pendCnt_d = pendCnt_q + 2'd1;
      end else if (!expire && rfStart) begin
        pendCnt_d = pendCnt_q - 2'd1;
      end
    end
  end

  // Scheduler state, round-robin pointer and refresh bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lastWr_q   <= 1'b0;
      pendCnt_q  <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lastWr_q   <= lastWr_d;
      pendCnt_q  <= pendCnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign grant       = ownerOf(state_q);
  assign wr_gnt      = grant.wr;
  assign rd_gnt      = grant.rd;
  assign rf_gnt      = grant.rf;
  assign busy        = (state_q != ST_IDLE);
  assign rf_pend_cnt = pendCnt_q;
  assign rf_overflow = overflow_q;

endmodule
